// File: rtl/buffer_narrow_to_wide.sv
// buffer_narrow_to_wide: packs RATIO narrow IN_W beats into one wide word and
// queues words in a first-word-fall-through FIFO of DEPTH entries. A flush
// emits the current partial word zero-padded, with a per-lane valid mask.
// Optional macro BUF_LEVEL_EN adds the level and almost_full outputs.

// One lane of the pack register. It captures its beat and clears whenever the
// word it belongs to is pushed. It also provides the lane's contribution to
// the word being pushed this cycle, including a beat that arrives on the
// push edge.
module buffer_narrow_to_wide_lane #(
  parameter int IN_W = 64,
  parameter int LANE = 0,
  parameter int FW   = 4
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            wr,
  input  logic            drop,
  input  logic [FW-1:0]   fill,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] word,
  output logic            mask
);
  logic [IN_W-1:0] q;

  // Lane storage: cleared on reset/clear or push so that unused lanes pad with zero
  always_ff @(posedge clk) begin
    if (srst || drop) q <= '0;
    else if (wr)      q <= din;
  end

  assign word = wr ? din : q;
  // Lane is valid in the pushed word when it lies below the fill level
  assign mask = (FW'(LANE) < fill);
endmodule

module buffer_narrow_to_wide #(
  parameter int IN_W  = 64,
  parameter int RATIO = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output logic                  empty
`ifdef BUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                  almost_full
`endif
);
  localparam int LW = $clog2(RATIO);
  localparam int FW = $clog2(RATIO + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = IN_W * RATIO;

  logic                        srst;
  logic [LW-1:0]               lane;
  logic                        flush_pending;
  logic                        accept;
  logic                        last_beat;
  logic                        do_flush;
  logic                        push;
  logic                        pop;
  logic [FW-1:0]               fill;
  logic [RATIO-1:0][IN_W-1:0]  word_lanes;
  logic [RATIO-1:0]            mask_lanes;

  logic [WW-1:0]               mem_data [DEPTH];
  logic [RATIO-1:0]            mem_mask [DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;

  assign srst = rst || clr;

  // Handshakes come from registered state only, so a pop while full frees
  // the slot for the following cycle.
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && !flush_pending;
  assign out_valid = !empty;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign last_beat = accept && (lane == LW'(RATIO - 1));
  // A flush (new or deferred) only acts once there is room; an empty lane-0
  // flush with no beat pushes nothing.
  assign do_flush  = (flush || flush_pending) && !full;
  assign push      = last_beat || (do_flush && (accept || (lane != '0)));
  assign fill      = FW'(lane) + FW'(accept);

  genvar k;
  generate
    for (k = 0; k < RATIO; k++) begin : g_lane
      buffer_narrow_to_wide_lane #(
        .IN_W (IN_W),
        .LANE (k),
        .FW   (FW)
      ) u_lane (
        .clk  (clk),
        .srst (srst),
        .wr   (accept && (lane == LW'(k))),
        .drop (push),
        .fill (fill),
        .din  (in_data),
        .word (word_lanes[k]),
        .mask (mask_lanes[k])
      );
    end
  endgenerate

  // Lane counter: advances per accepted beat, returns to 0 on any push
  always_ff @(posedge clk) begin
    if (srst)        lane <= '0;
    else if (push)   lane <= '0;
    else if (accept) lane <= lane + 1'b1;
  end

  // Flush arriving while full is remembered until a slot frees; repeats are absorbed
  always_ff @(posedge clk) begin
    if (srst)      flush_pending <= 1'b0;
    else if (full) flush_pending <= flush_pending || flush;
    else           flush_pending <= 1'b0;
  end

  // FIFO storage: written on push, not reset (the output is gated while empty)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_lanes;
      mem_mask[wr_ptr] <= mask_lanes;
    end
  end

  // FIFO pointers wrap modulo DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Word count 0..DEPTH; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk) begin
    if (srst)               count <= '0;
    else if (push && !pop)  count <= count + 1'b1;
    else if (pop && !push)  count <= count - 1'b1;
  end

  assign out_data = empty ? '0 : mem_data[rd_ptr];
  assign out_mask = empty ? '0 : mem_mask[rd_ptr];

`ifdef BUF_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= (AW+1)'(DEPTH - 1));
`endif
endmodule
